// File: rtl/alu_operand_stage.sv
// ALU operand stage: register-file bypass from EX/MEM and MEM/WB, load-use
// hazard detection, and a single valid/ready holding register feeding the ALU.
module alu_operand_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  id_func,
  input  logic [4:0]  id_shamt,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic        id_use_imm,
  input  logic        id_is_load,
  input  logic        id_reg_write,
  input  logic        exmem_reg_write,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_reg_write,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_result,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [5:0]  ex_func,
  output logic [4:0]  ex_shamt,
  output logic [31:0] ex_A,
  output logic [31:0] ex_B,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        ex_is_load,
  output logic [15:0] hazard_stall_cnt
);

  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic        ex_use_imm;
  logic        hazard;
  logic        capture;
  logic [31:0] id_a;
  logic [31:0] id_b;
  logic [31:0] hold_a;
  logic [31:0] hold_b;

  // Register 0 is hard-wired zero and never a bypass or hazard match; EX/MEM wins.
  function automatic logic [31:0] fwd(
    input logic [4:0]  r,
    input logic [31:0] v,
    input logic        em_we,
    input logic [4:0]  em_rd,
    input logic [31:0] em_res,
    input logic        mw_we,
    input logic [4:0]  mw_rd,
    input logic [31:0] mw_res
  );
    if (r == 5'd0)                  return '0;
    else if (em_we && em_rd == r)   return em_res;
    else if (mw_we && mw_rd == r)   return mw_res;
    else                            return v;
  endfunction

  always_comb begin
    hazard = ex_valid && ex_is_load && ex_reg_write && (ex_rd != 5'd0) &&
             ((ex_rd == id_rs) || ((ex_rd == id_rt) && !id_use_imm));
    in_ready = (!ex_valid || ex_ready) && !hazard && !flush;
    capture  = in_valid && in_ready;
    id_a   = fwd(id_rs, id_rs_data, exmem_reg_write, exmem_rd, exmem_result,
                 memwb_reg_write, memwb_rd, memwb_result);
    id_b   = id_use_imm ? id_imm
                        : fwd(id_rt, id_rt_data, exmem_reg_write, exmem_rd, exmem_result,
                              memwb_reg_write, memwb_rd, memwb_result);
    // While stalled, the held operand stands in for the register-file value.
    hold_a = fwd(ex_rs, ex_A, exmem_reg_write, exmem_rd, exmem_result,
                 memwb_reg_write, memwb_rd, memwb_result);
    hold_b = ex_use_imm ? ex_B
                        : fwd(ex_rt, ex_B, exmem_reg_write, exmem_rd, exmem_result,
                              memwb_reg_write, memwb_rd, memwb_result);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_func      <= '0;
      ex_shamt     <= '0;
      ex_A         <= '0;
      ex_B         <= '0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_is_load   <= 1'b0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_use_imm   <= 1'b0;
    end else if (flush) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_is_load   <= 1'b0;
    end else if (capture) begin
      ex_valid     <= 1'b1;
      ex_func      <= id_func;
      ex_shamt     <= id_shamt;
      ex_A         <= id_a;
      ex_B         <= id_b;
      ex_rd        <= id_rd;
      ex_reg_write <= id_reg_write;
      ex_is_load   <= id_is_load;
      ex_rs        <= id_rs;
      ex_rt        <= id_rt;
      ex_use_imm   <= id_use_imm;
    end else if (ex_valid && ex_ready) begin
      ex_valid <= 1'b0;
    end else if (ex_valid) begin
      ex_A <= hold_a;
      ex_B <= hold_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hazard_stall_cnt <= '0;
    end else if (hazard && in_valid && !flush && (hazard_stall_cnt != '1)) begin
      hazard_stall_cnt <= hazard_stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed and randomized checks of alu_operand_stage against a transaction-level
// model of the held instruction, its bypassed operands and the bubble counter.
module tb_alu_operand_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  id_func;
  logic [4:0]  id_shamt;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic        id_use_imm;
  logic        id_is_load;
  logic        id_reg_write;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [5:0]  ex_func;
  logic [4:0]  ex_shamt;
  logic [31:0] ex_A;
  logic [31:0] ex_B;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_is_load;
  logic [15:0] hazard_stall_cnt;

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .id_func(id_func), .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_is_load(id_is_load), .id_reg_write(id_reg_write),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_func(ex_func),
    .ex_shamt(ex_shamt), .ex_A(ex_A), .ex_B(ex_B), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .hazard_stall_cnt(hazard_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned passed = 0;
  int unsigned total  = 0;

  // Model of the instruction the stage should currently be holding.
  logic        m_valid;
  logic [5:0]  m_func;
  logic [4:0]  m_shamt;
  logic [31:0] m_A;
  logic [31:0] m_B;
  logic [4:0]  m_rd;
  logic        m_rw;
  logic        m_ld;
  logic [4:0]  m_rs;
  logic [4:0]  m_rt;
  logic        m_imm;
  logic [15:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mfwd(input logic [4:0] r, input logic [31:0] v);
    if (r == 0) return 32'd0;
    if (exmem_reg_write && exmem_rd == r) return exmem_result;
    if (memwb_reg_write && memwb_rd == r) return memwb_result;
    return v;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_func = 0; m_shamt = 0; m_A = 0; m_B = 0; m_rd = 0;
    m_rw = 0; m_ld = 0; m_rs = 0; m_rt = 0; m_imm = 0; m_cnt = 0;
  endtask

  task automatic idle();
    in_valid = 0; flush = 0; ex_ready = 1;
    id_func = 0; id_shamt = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_use_imm = 0; id_is_load = 0; id_reg_write = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic check_outputs();
    chk("ex_valid", 32'(ex_valid), 32'(m_valid));
    chk("stall_cnt", 32'(hazard_stall_cnt), 32'(m_cnt));
    if (m_valid) begin
      chk("ex_func", 32'(ex_func), 32'(m_func));
      chk("ex_shamt", 32'(ex_shamt), 32'(m_shamt));
      chk("ex_A", ex_A, m_A);
      chk("ex_B", ex_B, m_B);
      chk("ex_rd", 32'(ex_rd), 32'(m_rd));
      chk("ex_reg_write", 32'(ex_reg_write), 32'(m_rw));
      chk("ex_is_load", 32'(ex_is_load), 32'(m_ld));
    end
  endtask

  // One clock: inputs are already applied; check in_ready, advance model, check outputs.
  task automatic cycle(input bit do_chk);
    logic hz, rdy;
    #1;
    hz  = m_valid && m_ld && m_rw && (m_rd != 0) &&
          ((m_rd == id_rs) || ((m_rd == id_rt) && !id_use_imm));
    rdy = (!m_valid || ex_ready) && !hz && !flush;
    if (do_chk) chk("in_ready", 32'(in_ready), 32'(rdy));
    if (hz && in_valid && !flush && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    if (flush) begin
      m_valid = 0; m_rw = 0; m_ld = 0;
    end else if (in_valid && rdy) begin
      m_valid = 1; m_func = id_func; m_shamt = id_shamt; m_rd = id_rd;
      m_rw = id_reg_write; m_ld = id_is_load; m_rs = id_rs; m_rt = id_rt;
      m_imm = id_use_imm;
      m_A = mfwd(id_rs, id_rs_data);
      m_B = id_use_imm ? id_imm : mfwd(id_rt, id_rt_data);
    end else if (m_valid && ex_ready) begin
      m_valid = 0;
    end else if (m_valid) begin
      m_A = mfwd(m_rs, m_A);
      if (!m_imm) m_B = mfwd(m_rt, m_B);
    end
    @(posedge clk);
    #1;
    if (do_chk) check_outputs();
  endtask

  initial begin
    idle();
    model_reset();
    rst_n = 0;
    #12;
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_ex_A", ex_A, 32'd0);
    chk("rst_ex_B", ex_B, 32'd0);
    chk("rst_ex_func", 32'(ex_func), 32'd0);
    chk("rst_ctl", {30'd0, ex_reg_write, ex_is_load}, 32'd0);
    chk("rst_cnt", 32'(hazard_stall_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // Basic capture
    in_valid = 1; id_func = 6'h20; id_rs = 1; id_rs_data = 5; id_rt = 2; id_rt_data = 7;
    id_rd = 3; id_reg_write = 1;
    cycle(1);
    chk("basic_valid", 32'(ex_valid), 32'd1);
    chk("basic_A", ex_A, 32'd5);
    chk("basic_B", ex_B, 32'd7);
    chk("basic_func", 32'(ex_func), 32'h20);

    // Forwarding priority and register zero
    id_rs = 3; id_rs_data = 32'h33;
    exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'hAA;
    memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'hBB;
    cycle(1);
    chk("fwd_exmem", ex_A, 32'hAA);
    exmem_reg_write = 0;
    cycle(1);
    chk("fwd_memwb", ex_A, 32'hBB);
    id_rs = 0; exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0;
    cycle(1);
    chk("fwd_r0", ex_A, 32'd0);

    // Load-use bubble then MEM/WB forward
    idle();
    in_valid = 1; id_is_load = 1; id_reg_write = 1; id_rd = 4; id_rs = 1; id_rs_data = 1;
    cycle(1);
    id_is_load = 0; id_rd = 7; id_rs = 4; id_rs_data = 32'hDEAD;
    cycle(1);
    chk("lu_bubble", 32'(ex_valid), 32'd0);
    chk("lu_cnt", 32'(hazard_stall_cnt), 32'd1);
    memwb_reg_write = 1; memwb_rd = 4; memwb_result = 32'h4444;
    cycle(1);
    chk("lu_capture_A", ex_A, 32'h4444);

    // Hold refresh of a register B operand
    idle();
    in_valid = 1; id_func = 6'h11; id_rs = 2; id_rs_data = 32'h22; id_rt = 6; id_rt_data = 32'h66;
    cycle(1);
    in_valid = 0; ex_ready = 0;
    cycle(1);
    memwb_reg_write = 1; memwb_rd = 6; memwb_result = 32'h1234;
    cycle(1);
    memwb_reg_write = 0;
    cycle(1);
    chk("hold_B", ex_B, 32'h1234);
    chk("hold_func", 32'(ex_func), 32'h11);
    ex_ready = 1;
    cycle(1);

    // Flush wins over capture
    in_valid = 1; id_rd = 9; id_reg_write = 1; id_is_load = 1; id_rs = 1;
    cycle(1);
    flush = 1; ex_ready = 0; id_is_load = 0; id_rd = 10;
    cycle(1);
    chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_ctl", {30'd0, ex_reg_write, ex_is_load}, 32'd0);
    flush = 0; in_valid = 0; ex_ready = 1;
    cycle(1);

    // Randomized traffic with narrow indices so bypasses and hazards collide
    for (int i = 0; i < 600; i++) begin
      in_valid        = ($urandom_range(0, 3) != 0);
      ex_ready        = ($urandom_range(0, 3) != 0);
      flush           = ($urandom_range(0, 15) == 0);
      id_func         = 6'($urandom);
      id_shamt        = 5'($urandom);
      id_rs           = 5'($urandom_range(0, 7));
      id_rt           = 5'($urandom_range(0, 7));
      id_rd           = 5'($urandom_range(0, 7));
      id_rs_data      = $urandom;
      id_rt_data      = $urandom;
      id_imm          = $urandom;
      id_use_imm      = ($urandom_range(0, 3) == 0);
      id_is_load      = ($urandom_range(0, 2) == 0);
      id_reg_write    = ($urandom_range(0, 3) != 0);
      exmem_reg_write = ($urandom_range(0, 1) != 0);
      exmem_rd        = 5'($urandom_range(0, 7));
      exmem_result    = $urandom;
      memwb_reg_write = ($urandom_range(0, 1) != 0);
      memwb_rd        = 5'($urandom_range(0, 7));
      memwb_result    = $urandom;
      cycle(1);
    end

    // Saturate the bubble counter with a stalled load feeding a dependent offer
    idle();
    cycle(1);
    in_valid = 1; id_is_load = 1; id_reg_write = 1; id_rd = 5;
    cycle(1);
    ex_ready = 0; id_is_load = 0; id_rd = 1; id_rs = 5;
    for (int i = 0; i < 65540; i++) cycle(0);
    cycle(1);
    chk("sat_cnt", 32'(hazard_stall_cnt), 32'hFFFF);
    cycle(1);
    chk("sat_hold", 32'(hazard_stall_cnt), 32'hFFFF);

    // Asynchronous reset while holding
    idle();
    in_valid = 1; id_rs = 1; id_rs_data = 32'h55; id_rd = 2; id_reg_write = 1;
    cycle(1);
    in_valid = 0; ex_ready = 0;
    cycle(1);
    chk("pre_rst_valid", 32'(ex_valid), 32'd1);
    #2; rst_n = 0;
    #1;
    chk("arst_valid", 32'(ex_valid), 32'd0);
    chk("arst_A", ex_A, 32'd0);
    chk("arst_cnt", 32'(hazard_stall_cnt), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    model_reset();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    idle();
    in_valid = 1; id_rs = 2; id_rs_data = 32'h77; id_rt = 0; id_rt_data = 32'h99;
    cycle(1);
    chk("post_rst_A", ex_A, 32'h77);
    chk("post_rst_B", ex_B, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
